// File: rtl/mem_pkg.sv
// Shared definitions for the data memory stage:
// load/store size codes and the byte-enable type.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [3:0] be_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, extension for loads,
// and alignment/legality checking of one access.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        store,
   input  logic [1:0]  lane,
   input  logic [31:0] write_data,
   input  logic [31:0] raw,
   output be_t         be,
   output logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        fault
);

   logic [7:0]  bsel;
   logic [15:0] hsel;

   assign bsel = raw[{lane, 3'b000} +: 8];
   assign hsel = lane[1] ? raw[31:16] : raw[15:0];

   always_comb begin
      be    = '0;
      wdata = '0;
      rdata = '0;
      fault = 1'b0;
      case (funct3)
         F3_B: begin
            be    = be_t'(4'b0001 << lane);
            wdata = {4{write_data[7:0]}};
            rdata = {{24{bsel[7]}}, bsel};
         end
         F3_BU: begin
            // there is no unsigned store encoding
            fault = store;
            be    = be_t'(4'b0001 << lane);
            wdata = {4{write_data[7:0]}};
            rdata = {24'h0, bsel};
         end
         F3_H: begin
            fault = lane[0];
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{write_data[15:0]}};
            rdata = {{16{hsel[15]}}, hsel};
         end
         F3_HU: begin
            fault = lane[0];
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{write_data[15:0]}};
            rdata = {16'h0, hsel};
         end
         F3_W: begin
            fault = |lane;
            be    = 4'b1111;
            wdata = write_data;
            rdata = raw;
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_memory_unit.sv
// RV32I data memory: word array with byte enables,
// combinational loads and a sticky first-fault record.
module data_memory_unit
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        fault_clr,
   output logic [31:0] read_data,
   output logic        misaligned,
   output logic        fault_sticky,
   output logic [31:0] fault_addr
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0] raw;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        fault;
   logic        we;
   be_t         be;

   assign idx = addr[AW+1:2];
   assign raw = mem[idx];

   mem_lane_align u_align (
      .funct3     (funct3),
      .store      (MemWrite),
      .lane       (addr[1:0]),
      .write_data (write_data),
      .raw        (raw),
      .be         (be),
      .wdata      (wdata),
      .rdata      (rdata),
      .fault      (fault)
   );

   assign misaligned = (MemRead | MemWrite) & fault;
   assign read_data  = (MemRead & ~fault) ? rdata : 32'h0;
   assign we         = MemWrite & ~fault;

   // rst_n gates the write so a store caught by reset is dropped
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_sticky <= 1'b0;
         fault_addr   <= '0;
      end else if (misaligned && (!fault_sticky || fault_clr)) begin
         fault_sticky <= 1'b1;
         fault_addr   <= addr;
      end else if (fault_clr && !misaligned) begin
         fault_sticky <= 1'b0;
         fault_addr   <= '0;
      end
   end

endmodule
